// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/inst_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds the CPU until it lands.
// Optional trailing XOR checksum when INST_LOADER_CHECKSUM_EN is defined.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  // Wide enough that no 16-bit word count can alias past the depth check.
  localparam int unsigned PROD_W = 18;

  state_e            state_q, state_d;
  logic [7:0]        wcnt_hi_q, wcnt_hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              in_ready_d, mem_we_d, cpu_hold_d, done_d, error_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic              accept;
  logic [15:0]       wcnt;
  logic [PROD_W-1:0] nbytes;
  logic              overflow;
  logic              last_data;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        acc_q, acc_d;
`endif

  assign accept    = in_valid && in_ready;
  assign wcnt      = {wcnt_hi_q, in_data};
  assign nbytes    = PROD_W'(wcnt) * PROD_W'(BYTES_PER_WORD);
  assign overflow  = nbytes > PROD_W'(DEPTH);
  assign last_data = cnt_q == (total_q - CNT_W'(1));

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    wcnt_hi_d   = wcnt_hi_q;
    cnt_d       = cnt_q;
    total_d     = total_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    done_d      = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    acc_d       = acc_q;
`endif

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR_HI;
          cnt_d   = '0;
`ifdef INST_LOADER_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      HDR_HI: begin
        if (accept) begin
          wcnt_hi_d = in_data;
          state_d   = HDR_LO;
`ifdef INST_LOADER_CHECKSUM_EN
          acc_d     = acc_q ^ in_data;
`endif
        end
      end
      HDR_LO: begin
        if (accept) begin
          total_d = CNT_W'(nbytes);
`ifdef INST_LOADER_CHECKSUM_EN
          acc_d   = acc_q ^ in_data;
`endif
          if (overflow) begin
            state_d = ERR;
          end else if (wcnt == 16'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = in_data;
          cnt_d       = cnt_q + CNT_W'(1);
`ifdef INST_LOADER_CHECKSUM_EN
          acc_d       = acc_q ^ in_data;
          if (last_data) state_d = CSUM;
`else
          if (last_data) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          if (in_data == acc_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    in_ready_d = state_d inside {HDR_HI, HDR_LO, DATA, CSUM};
    cpu_hold_d = state_d != DONE;
    error_d    = state_d == ERR;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wcnt_hi_q <= '0;
      cnt_q     <= '0;
      total_q   <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wcnt_hi_q <= wcnt_hi_d;
      cnt_q     <= cnt_d;
      total_q   <= total_d;
      in_ready  <= in_ready_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      cpu_hold  <= cpu_hold_d;
      done      <= done_d;
      error     <= error_d;
`ifdef INST_LOADER_CHECKSUM_EN
      acc_q     <= acc_d;
`endif
    end
  end

endmodule
